// File: rtl/cpu_dbg_pkg.sv
// Run-control state encodings shared by the run controller and the board LED decoder.
package cpu_dbg_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET  = 2'b00,
    ST_PAUSED = 2'b01,
    ST_RUN    = 2'b10,
    ST_PACED  = 2'b11
  } run_state_e;

  // Observation bundle: FSM state plus the three debounced input levels.
  typedef struct packed {
    run_state_e state;
    logic       run_lvl;
    logic       step_lvl;
    logic       pace_lvl;
  } dbg_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Board-side bundle between the raw buttons/switch, the run controller and the CPU core.
interface cpu_run_ctrl_if;

  // No valid/ready handshake here: buttons and switch are raw levels, CPU_RST_N/HALT
  // are levels, and STEP_PULSE is a one-cycle strobe the consumer cannot back-pressure.
  logic                             BTN_RUN;
  logic                             BTN_STEP;
  logic                             SW_PACE;
  logic                             CPU_RST_N;
  logic                             HALT;
  logic                             STEP_PULSE;
  logic [cpu_dbg_pkg::STATE_W-1:0]  STATE;
  cpu_dbg_pkg::dbg_t                DBG;

  modport master (
    output BTN_RUN, BTN_STEP, SW_PACE,
    input  CPU_RST_N, HALT, STEP_PULSE, STATE, DBG
  );

  modport slave (
    input  BTN_RUN, BTN_STEP, SW_PACE,
    output CPU_RST_N, HALT, STEP_PULSE, STATE, DBG
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability counter for one raw button or switch.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 26
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts consecutive cycles the synchronised input disagrees with level_q.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync2_q;
        rise_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller owning the CPU reset and halt: free-run, paced ticks, or paused single-step.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int TICK_DIV        = 50000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int RESET_HOLD      = 16,
  parameter int CNT_W           = 26
) (
  input  logic          CLK100MHZ,
  input  logic          RST,
  cpu_run_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TICK_PRE  = CNT_W'(TICK_DIV - 2);

  logic run_level, run_rise;
  logic step_level, step_rise;
  logic pace_level, pace_rise;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_run (
    .clk_i(CLK100MHZ), .rst_i(RST), .raw_i(bus.BTN_RUN),
    .level(run_level), .rise(run_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_step (
    .clk_i(CLK100MHZ), .rst_i(RST), .raw_i(bus.BTN_STEP),
    .level(step_level), .rise(step_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_pace (
    .clk_i(CLK100MHZ), .rst_i(RST), .raw_i(bus.SW_PACE),
    .level(pace_level), .rise(pace_rise)
  );

  run_state_e       state_q;
  logic [CNT_W-1:0] hold_q;
  logic [CNT_W-1:0] tick_q;
  logic             rst_n_q;
  logic             halt_q;
  logic             step_q;

  // halt_q/step_q are computed one cycle ahead so they line up with tick_q == TICK_LAST.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      state_q <= ST_RESET;
      hold_q  <= '0;
      tick_q  <= '0;
      rst_n_q <= 1'b0;
      halt_q  <= 1'b1;
      step_q  <= 1'b0;
    end else begin
      halt_q <= 1'b1;
      step_q <= 1'b0;
      tick_q <= '0;
      hold_q <= '0;
      unique case (state_q)
        ST_RESET: begin
          if (!rst_n_q) begin
            hold_q <= hold_q + CNT_W'(1);
            if (hold_q == HOLD_LAST) rst_n_q <= 1'b1;
          end else begin
            state_q <= ST_PAUSED;
          end
        end
        ST_PAUSED: begin
          if (run_rise) begin
            state_q <= pace_level ? ST_PACED : ST_RUN;
            halt_q  <= pace_level;
          end else if (step_rise) begin
            halt_q <= 1'b0;
            step_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (run_rise) begin
            state_q <= ST_PAUSED;
          end else if (pace_rise) begin
            state_q <= ST_PACED;
          end else begin
            halt_q <= 1'b0;
          end
        end
        ST_PACED: begin
          if (run_rise) begin
            state_q <= ST_PAUSED;
          end else if (!pace_level) begin
            state_q <= ST_RUN;
            halt_q  <= 1'b0;
          end else begin
            tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + CNT_W'(1);
            if (tick_q == TICK_PRE) begin
              halt_q <= 1'b0;
              step_q <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.CPU_RST_N  = rst_n_q;
  assign bus.HALT       = halt_q;
  assign bus.STEP_PULSE = step_q;
  assign bus.STATE      = state_q;
  assign bus.DBG        = '{state: state_q, run_lvl: run_level,
                            step_lvl: step_level, pace_lvl: pace_level};

endmodule
